aib_ch_prbs_checker: RTL and testbench

//  Per-channel PRBS receive checker at the slave-side AIB channel output of the EMIB die-to-die model.

---
 rtl/aib_prbs_pkg.sv | 45 ++++
 rtl/aib_ch_prbs_checker_if.sv | 12 +
 rtl/aib_prbs_popcnt.sv | 37 +++
 rtl/aib_ch_prbs_checker.sv | 228 ++++++++++++++++++++++
 tb/tb_aib_ch_prbs_checker.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/aib_prbs_pkg.sv
// Shared types and PRBS helpers for the AIB channel PRBS checker.
package aib_prbs_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEEK   = 2'd1,
    ST_LOCKED = 2'd2
  } prbs_state_e;

  // Feedback tap positions for x^N + x^TAP + 1
  localparam int unsigned PRBS7_TAP  = 6;
  localparam int unsigned PRBS31_TAP = 28;

  // Storage limits of the word predictor
  localparam int unsigned HIST_MAX = 32;
  localparam int unsigned WORD_MAX = 128;

  function automatic int unsigned prbs_tap(input int unsigned n);
    return (n == 7) ? PRBS7_TAP : PRBS31_TAP;
  endfunction

  // Unrolled serial LFSR: hist[n-1] is the newest bit, result bit 0 is the earliest generated bit.
  function automatic logic [WORD_MAX-1:0] prbs_next_word(
    input logic [HIST_MAX-1:0] hist,
    input int unsigned         n,
    input int unsigned         tap,
    input int unsigned         steps
  );
    logic [HIST_MAX-1:0] h;
    logic [WORD_MAX-1:0] w;
    logic                nb;
    h = hist;
    w = '0;
    for (int unsigned i = 0; i < WORD_MAX; i++) begin
      if (i < steps) begin
        nb           = h[0] ^ h[5'(n - tap)];
        w[7'(i)]     = nb;
        h            = h >> 1;
        h[5'(n - 1)] = nb;
      end
    end
    return w;
  endfunction

endpackage

// File: rtl/aib_ch_prbs_checker_if.sv
// Receive-side beat interface feeding one channel PRBS checker.
interface aib_ch_prbs_checker_if #(
  parameter int unsigned DATA_W = 40
);
  logic              i_en;
  logic              i_valid;
  logic [DATA_W-1:0] i_data;
  logic              i_clr;

  modport master (output i_en, output i_valid, output i_data, output i_clr);
  modport slave  (input  i_en, input  i_valid, input  i_data, input  i_clr);
endinterface

// File: rtl/aib_prbs_popcnt.sv
// Population count of a DATA_W-bit vector, optionally registered.
module aib_prbs_popcnt #(
  parameter int unsigned DATA_W = 40,
  parameter bit          PIPE   = 1'b0,
  parameter int unsigned PC_W   = $clog2(DATA_W + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] bits,
  output logic [PC_W-1:0]   pop_c
);

  logic [PC_W-1:0] sum;

  // Bit sum; synthesis balances it into an adder tree
  always_comb begin
    sum = '0;
    for (int unsigned i = 0; i < DATA_W; i++) begin
      sum = sum + PC_W'(bits[i]);
    end
  end

  if (PIPE) begin : g_pipe
    logic [PC_W-1:0] sum_q;
    // Optional pipeline stage on the count
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sum_q <= '0;
      else        sum_q <= sum;
    end
    assign pop_c = sum_q;
  end else begin : g_comb
    logic unused_clk;
    assign unused_clk = clk ^ rst_n;
    assign pop_c      = sum;
  end

endmodule

// File: rtl/aib_ch_prbs_checker.sv
// Per-channel self-synchronising PRBS7/PRBS31 receive checker with lock tracking and error count.
// Optional first-error log ports/logic enabled by defining AIB_PRBS_ERR_LOG_EN.
module aib_ch_prbs_checker
  import aib_prbs_pkg::*;
#(
  parameter int unsigned DATA_W   = 40,
  parameter int unsigned PRBS_N   = 31,
  parameter int unsigned LOCK_CNT = 16,
  parameter int unsigned LOL_CNT  = 4,
  parameter int unsigned CNT_W    = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  aib_ch_prbs_checker_if.slave rx,
  output logic                 o_lock,
  output logic [1:0]           o_state,
  output logic                 o_err_word,
  output logic [CNT_W-1:0]     o_err_cnt,
  output logic                 o_lol_sticky
`ifdef AIB_PRBS_ERR_LOG_EN
  ,
  output logic [DATA_W-1:0]    o_first_err_mask,
  output logic [15:0]          o_first_err_word
`endif
);

  localparam int unsigned TAP   = prbs_tap(PRBS_N);
  localparam int unsigned PC_W  = $clog2(DATA_W + 1);
  localparam int unsigned RUN_W = $clog2(LOCK_CNT + 1);
  localparam int unsigned BAD_W = $clog2(LOL_CNT + 1);

  if (!(PRBS_N == 7 || PRBS_N == 31) || DATA_W < PRBS_N || DATA_W > WORD_MAX ||
      LOCK_CNT < 1 || LOL_CNT < 1 || CNT_W < PC_W) begin : g_bad_cfg
    $error("aib_ch_prbs_checker: unsupported parameter set");
  end

  prbs_state_e         state_q, state_d;
  logic [PRBS_N-1:0]   hist_q, hist_d;
  logic                seeded_q, seeded_d;
  logic [RUN_W-1:0]    run_q, run_d;
  logic [BAD_W-1:0]    bad_q, bad_d;
  logic [CNT_W-1:0]    err_cnt_q, err_cnt_d;
  logic                lol_q, lol_d;
  logic                err_word_q, err_word_d;
  logic                lock_q;
  logic                lol_evt;

  logic [DATA_W-1:0]   exp_word;
  logic [DATA_W-1:0]   mismatch;
  logic                word_err;
  logic [PC_W-1:0]     pop_c;
  logic [CNT_W:0]      err_sum;
  logic [CNT_W-1:0]    err_sat;

  // Expected word from the history, mismatch against the received word
  assign exp_word = DATA_W'(prbs_next_word(HIST_MAX'(hist_q), PRBS_N, TAP, DATA_W));
  assign mismatch = rx.i_data ^ exp_word;
  assign word_err = |mismatch;

  aib_prbs_popcnt #(
    .DATA_W (DATA_W),
    .PIPE   (1'b0),
    .PC_W   (PC_W)
  ) u_popcnt (
    .clk   (clk),
    .rst_n (rst_n),
    .bits  (mismatch),
    .pop_c (pop_c)
  );

  // Saturating error accumulation
  assign err_sum = {1'b0, err_cnt_q} + (CNT_W + 1)'(pop_c);
  assign err_sat = err_sum[CNT_W] ? {CNT_W{1'b1}} : err_sum[CNT_W-1:0];

  // Next-state, history and counter logic
  always_comb begin
    state_d    = state_q;
    hist_d     = hist_q;
    seeded_d   = seeded_q;
    run_d      = run_q;
    bad_d      = bad_q;
    err_cnt_d  = err_cnt_q;
    lol_d      = lol_q;
    err_word_d = 1'b0;
    lol_evt    = 1'b0;

    if (!rx.i_en) begin
      state_d  = ST_IDLE;
      seeded_d = 1'b0;
      run_d    = '0;
      bad_d    = '0;
    end else begin
      case (state_q)
        ST_IDLE: state_d = ST_SEEK;

        ST_SEEK: begin
          if (rx.i_valid) begin
            hist_d   = rx.i_data[DATA_W-1 -: PRBS_N];
            seeded_d = 1'b1;
            if (!seeded_q || word_err) begin
              run_d = '0;
            end else if (run_q == RUN_W'(LOCK_CNT - 1)) begin
              run_d   = '0;
              bad_d   = '0;
              state_d = ST_LOCKED;
            end else begin
              run_d = RUN_W'(run_q + 1'b1);
            end
          end
        end

        ST_LOCKED: begin
          if (rx.i_valid) begin
            // Advance from the prediction so received errors never feed back
            hist_d     = exp_word[DATA_W-1 -: PRBS_N];
            err_cnt_d  = err_sat;
            err_word_d = word_err;
            if (word_err) begin
              if (bad_q == BAD_W'(LOL_CNT - 1)) begin
                state_d  = ST_SEEK;
                lol_evt  = 1'b1;
                bad_d    = '0;
                run_d    = '0;
                seeded_d = 1'b0;
              end else begin
                bad_d = BAD_W'(bad_q + 1'b1);
              end
            end else begin
              bad_d = '0;
            end
          end
        end

        default: state_d = ST_IDLE;
      endcase
    end

    // Clear beats a same-cycle increment; a same-cycle loss of lock still sets the sticky
    if (rx.i_clr) begin
      err_cnt_d = '0;
      lol_d     = 1'b0;
    end
    if (lol_evt) lol_d = 1'b1;
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      hist_q     <= '0;
      seeded_q   <= 1'b0;
      run_q      <= '0;
      bad_q      <= '0;
      err_cnt_q  <= '0;
      lol_q      <= 1'b0;
      err_word_q <= 1'b0;
      lock_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      hist_q     <= hist_d;
      seeded_q   <= seeded_d;
      run_q      <= run_d;
      bad_q      <= bad_d;
      err_cnt_q  <= err_cnt_d;
      lol_q      <= lol_d;
      err_word_q <= err_word_d;
      lock_q     <= (state_d == ST_LOCKED);
    end
  end

  assign o_lock       = lock_q;
  assign o_state      = state_q;
  assign o_err_word   = err_word_q;
  assign o_err_cnt    = err_cnt_q;
  assign o_lol_sticky = lol_q;

`ifdef AIB_PRBS_ERR_LOG_EN
  logic              checked_c;
  logic              log_full_q, log_full_d;
  logic [DATA_W-1:0] mask_q, mask_d;
  logic [15:0]       idx_q, idx_d;
  logic [15:0]       widx_q, widx_d;

  assign checked_c = rx.i_en && rx.i_valid && (state_q == ST_LOCKED);

  // Capture the first errored LOCKED word since reset or clear
  always_comb begin
    log_full_d = log_full_q;
    mask_d     = mask_q;
    idx_d      = idx_q;
    widx_d     = widx_q;
    if (state_q != ST_LOCKED) begin
      widx_d = '0;
    end else if (checked_c) begin
      if (widx_q != 16'hFFFF) widx_d = widx_q + 16'd1;
      if (word_err && !log_full_q) begin
        log_full_d = 1'b1;
        mask_d     = mismatch;
        idx_d      = widx_q;
      end
    end
    if (rx.i_clr) begin
      log_full_d = 1'b0;
      mask_d     = '0;
      idx_d      = '0;
    end
  end

  // Error log registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      log_full_q <= 1'b0;
      mask_q     <= '0;
      idx_q      <= '0;
      widx_q     <= '0;
    end else begin
      log_full_q <= log_full_d;
      mask_q     <= mask_d;
      idx_q      <= idx_d;
      widx_q     <= widx_d;
    end
  end

  assign o_first_err_mask = mask_q;
  assign o_first_err_word = idx_q;
`endif

endmodule

// File: tb/tb_aib_ch_prbs_checker.sv
// Directed bench for aib_ch_prbs_checker: PRBS31 instance (table + sequences) and PRBS7 instance (bubbles).
module tb_aib_ch_prbs_checker;

  localparam int unsigned DW = 40;
  localparam int unsigned CW = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  aib_ch_prbs_checker_if #(.DATA_W(DW)) rx_a ();
  aib_ch_prbs_checker_if #(.DATA_W(DW)) rx_b ();

  logic          lock_a, ew_a, lol_a;
  logic [1:0]    state_a;
  logic [CW-1:0] cnt_a;
  logic          lock_b, ew_b, lol_b;
  logic [1:0]    state_b;
  logic [CW-1:0] cnt_b;

  aib_ch_prbs_checker #(
    .DATA_W(DW), .PRBS_N(31), .LOCK_CNT(16), .LOL_CNT(4), .CNT_W(CW)
  ) u_dut_a (
    .clk(clk), .rst_n(rst_n), .rx(rx_a),
    .o_lock(lock_a), .o_state(state_a), .o_err_word(ew_a),
    .o_err_cnt(cnt_a), .o_lol_sticky(lol_a)
  );

  aib_ch_prbs_checker #(
    .DATA_W(DW), .PRBS_N(7), .LOCK_CNT(16), .LOL_CNT(4), .CNT_W(CW)
  ) u_dut_b (
    .clk(clk), .rst_n(rst_n), .rx(rx_b),
    .o_lock(lock_b), .o_state(state_b), .o_err_word(ew_b),
    .o_err_cnt(cnt_b), .o_lol_sticky(lol_b)
  );

  typedef struct packed {
    logic          valid;
    logic          clr;
    logic [DW-1:0] flip;
    logic          ew;
    logic [CW-1:0] cnt;
    logic          lk;
    logic          lol;
  } vec_t;

  vec_t tbl[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  logic [30:0]   g31 = '1;
  logic [6:0]    g7  = '1;
  logic [DW-1:0] w;
  logic          ew_seen;
  logic [CW-1:0] cnt_hold;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Independent serial generators, newest bit at index 0
  task automatic gen31(output logic [DW-1:0] o);
    logic b;
    for (int i = 0; i < int'(DW); i++) begin
      b    = g31[30] ^ g31[27];
      o[i] = b;
      g31  = {g31[29:0], b};
    end
  endtask

  task automatic gen7(output logic [DW-1:0] o);
    logic b;
    for (int i = 0; i < int'(DW); i++) begin
      b    = g7[6] ^ g7[5];
      o[i] = b;
      g7   = {g7[5:0], b};
    end
  endtask

  task automatic cyc_a(input logic v, input logic c, input logic [DW-1:0] d);
    @(negedge clk);
    rx_a.i_valid = v;
    rx_a.i_clr   = c;
    rx_a.i_data  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic cyc_b(input logic v, input logic [DW-1:0] d);
    @(negedge clk);
    rx_b.i_valid = v;
    rx_b.i_data  = d;
    @(posedge clk);
    #1;
  endtask

  function automatic void add(input logic v, input logic c, input logic [DW-1:0] f,
                              input logic e, input int cnt, input logic lk, input logic lol);
    vec_t r;
    r.valid = v;
    r.clr   = c;
    r.flip  = f;
    r.ew    = e;
    r.cnt   = CW'(cnt);
    r.lk    = lk;
    r.lol   = lol;
    tbl.push_back(r);
  endfunction

  // Relock A on clean words; lock must appear after exactly 17 valid words
  task automatic relock_a(input string tag);
    for (int k = 1; k <= 17; k++) begin
      gen31(w);
      cyc_a(1'b1, 1'b0, w);
      if (k == 16) check({tag, "_lock_after16"}, 64'(lock_a), 64'd0);
      if (k == 17) check({tag, "_lock_after17"}, 64'(lock_a), 64'd1);
    end
    check({tag, "_state_locked"}, 64'(state_a), 64'd2);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rx_a.i_en = 1'b0; rx_a.i_valid = 1'b0; rx_a.i_data = '0; rx_a.i_clr = 1'b0;
    rx_b.i_en = 1'b0; rx_b.i_valid = 1'b0; rx_b.i_data = '0; rx_b.i_clr = 1'b0;

    // Post-lock table for instance A
    add(1, 0, 40'h80_0000_0021, 1, 3, 1, 0);        // bits 0,5,39
    add(1, 0, '0, 0, 3, 1, 0);
    add(0, 0, 40'h12_3456_789A, 0, 3, 1, 0);        // bubble with garbage data
    add(1, 0, '0, 0, 3, 1, 0);
    for (int i = 0; i < 3; i++) add(1, 0, 40'h400, 1, 4 + i, 1, 0);
    add(1, 0, '0, 0, 6, 1, 0);                      // clean word resets errored run
    add(1, 0, 40'h400, 1, 7, 1, 0);
    add(1, 0, 40'h400, 1, 8, 1, 0);
    add(1, 0, 40'h400, 1, 9, 1, 0);
    add(1, 0, 40'h400, 1, 10, 0, 1);                // 4th errored word: loss of lock
    for (int k = 1; k <= 17; k++) add(1, 0, '0, 0, 10, (k == 17), 1);
    add(1, 1, '0, 0, 0, 1, 0);                      // clear
    for (int i = 1; i <= 6; i++) begin
      add(1, 0, {DW{1'b1}}, 1, 40 * i, 1, 0);
      add(1, 0, '0, 0, 40 * i, 1, 0);
    end
    add(1, 0, 40'h3FF, 1, 250, 1, 0);
    add(1, 0, '0, 0, 250, 1, 0);
    add(1, 0, 40'h3FF, 1, 255, 1, 0);               // 260 saturates
    add(1, 0, '0, 0, 255, 1, 0);
    add(1, 0, 40'h8, 1, 255, 1, 0);
    add(1, 1, 40'h7, 1, 0, 1, 0);                   // clear wins over increment
    add(1, 0, '0, 0, 0, 1, 0);
    add(1, 0, 40'h1, 1, 1, 1, 0);
    add(1, 0, 40'h1, 1, 2, 1, 0);
    add(1, 0, 40'h1, 1, 3, 1, 0);
    add(1, 1, 40'h1, 1, 0, 0, 1);                   // clear with LOL: sticky ends set

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_state_a", 64'(state_a), 64'd0);
    check("rst_lock_a", 64'(lock_a), 64'd0);
    check("rst_cnt_a", 64'(cnt_a), 64'd0);
    check("rst_lol_a", 64'(lol_a), 64'd0);
    check("rst_ew_a", 64'(ew_a), 64'd0);
    check("rst_state_b", 64'(state_b), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // PRBS31 clean lock and long clean run
    @(negedge clk);
    rx_a.i_en = 1'b1;
    @(posedge clk);
    #1;
    check("a_seek_entry", 64'(state_a), 64'd1);
    relock_a("t1");
    ew_seen = 1'b0;
    for (int k = 0; k < 1000; k++) begin
      gen31(w);
      cyc_a(1'b1, 1'b0, w);
      ew_seen |= ew_a;
    end
    check("t1_clean_cnt", 64'(cnt_a), 64'd0);
    check("t1_clean_ew", 64'(ew_seen), 64'd0);
    check("t1_clean_lock", 64'(lock_a), 64'd1);

    // Table-driven post-lock sequence
    foreach (tbl[r]) begin
      if (tbl[r].valid) gen31(w);
      else              w = 40'hC3_5A5A_0FF0;
      cyc_a(tbl[r].valid, tbl[r].clr, w ^ tbl[r].flip);
      check($sformatf("row%0d_err_word", r), 64'(ew_a), 64'(tbl[r].ew));
      check($sformatf("row%0d_err_cnt", r), 64'(cnt_a), 64'(tbl[r].cnt));
      check($sformatf("row%0d_lock", r), 64'(lock_a), 64'(tbl[r].lk));
      check($sformatf("row%0d_lol", r), 64'(lol_a), 64'(tbl[r].lol));
    end
    check("tbl_end_state_seek", 64'(state_a), 64'd1);
    rx_a.i_clr   = 1'b0;
    rx_a.i_valid = 1'b0;

    // PRBS7 with bubbles on instance B
    @(negedge clk);
    rx_b.i_en = 1'b1;
    @(posedge clk);
    #1;
    check("b_seek_entry", 64'(state_b), 64'd1);
    ew_seen = 1'b0;
    for (int k = 1; k <= 57; k++) begin
      gen7(w);
      cyc_b(1'b1, w);
      ew_seen |= ew_b;
      if (k == 17) check("b_lock_after17", 64'(lock_b), 64'd1);
      cyc_b(1'b0, 40'hA5_A5A5_A5A5);
      ew_seen |= ew_b;
      if (k == 16) check("b_lock_after16", 64'(lock_b), 64'd0);
    end
    check("b_clean_cnt", 64'(cnt_b), 64'd0);
    check("b_clean_ew", 64'(ew_seen), 64'd0);
    gen7(w);
    cyc_b(1'b1, w ^ 40'h4000_0004);
    check("b_err_word", 64'(ew_b), 64'd1);
    check("b_err_cnt", 64'(cnt_b), 64'd2);
    cyc_b(1'b0, 40'hFF_FFFF_FFFF);
    check("b_bubble_ew", 64'(ew_b), 64'd0);
    check("b_bubble_cnt", 64'(cnt_b), 64'd2);
    check("b_bubble_lock", 64'(lock_b), 64'd1);

    // Enable low: IDLE, counters held
    @(negedge clk);
    rx_b.i_en = 1'b0;
    @(posedge clk);
    #1;
    check("b_en_low_state", 64'(state_b), 64'd0);
    check("b_en_low_lock", 64'(lock_b), 64'd0);
    check("b_en_low_cnt", 64'(cnt_b), 64'd2);

    // All-zero stream: accepted limitation, it locks with no new errors
    @(negedge clk);
    rx_b.i_en = 1'b1;
    @(posedge clk);
    #1;
    for (int k = 1; k <= 17; k++) cyc_b(1'b1, '0);
    check("b_zero_lock", 64'(lock_b), 64'd1);
    check("b_zero_cnt", 64'(cnt_b), 64'd2);
    rx_b.i_valid = 1'b0;

    // Asynchronous reset mid-LOCKED on instance A
    relock_a("t6pre");
    gen31(w);
    cyc_a(1'b1, 1'b0, w ^ 40'h8);
    check("t6_pre_cnt", 64'(cnt_a), 64'd1);
    check("t6_pre_ew", 64'(ew_a), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rst_state", 64'(state_a), 64'd0);
    check("t6_rst_lock", 64'(lock_a), 64'd0);
    check("t6_rst_cnt", 64'(cnt_a), 64'd0);
    check("t6_rst_ew", 64'(ew_a), 64'd0);
    check("t6_rst_lol", 64'(lol_a), 64'd0);
    rx_a.i_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("t6_release_seek", 64'(state_a), 64'd1);
    relock_a("t6post");
    check("t6_post_cnt", 64'(cnt_a), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
